brick_map_arbiter: RTL and testbench

- Owns the single-port brick map RAM and shares it between three requesters: the video renderer (read), the ball physics (atomic hit = read-decrement-write) and the level loader (write).
- Tracks the number of live bricks and raises the one-cycle win pulse consumed by the game state controller.
- Sits between the physics, renderer and level-load logic and the brick map RAM, which has a 1-cycle read latency.

---
 rtl/brick_map_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_brick_map_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_map_arbiter.sv
// -----------------------------------------------------------------------------
// brick_map_arbiter
//
// Purpose:
//   Owns the single-port brick map RAM and shares it between three requesters:
//   the video renderer (read), the ball physics (atomic read-decrement-write
//   "hit") and the level loader (write). It also keeps the live-brick count and
//   raises a one-cycle win pulse when the last brick is destroyed.
//
// Build option:
//   VID_STALL_STATS_EN - when defined, vid_stall_cnt counts the cycles in which
//                        video requested but was not granted. When undefined,
//                        vid_stall_cnt is tied to 0.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   vid_req/vid_addr          video read request and address
//   vid_gnt                   video request accepted this cycle
//   vid_rvalid/vid_rdata      read data, one cycle after vid_gnt
//   hit_req/hit_addr          physics hit request, held until hit_ack
//   hit_ack/hit_miss/
//   hit_destroyed             hit completion pulse and its result flags
//   load_req/load_addr/
//   load_data/load_gnt        level loader write request and grant
//   cnt_clr                   zero the brick counter
//   mem_addr/mem_we/
//   mem_wdata/mem_rdata       single-port RAM, 1-cycle read latency
//   bricks_left               live-brick count
//   win                       one-cycle pulse when the last brick is destroyed
//   vid_stall_cnt             video stall statistic (0 when option disabled)
// -----------------------------------------------------------------------------
module brick_map_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 2,
  parameter int CNT_W     = 7,
  parameter int VID_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              hit_req,
  input  logic [ADDR_W-1:0] hit_addr,
  output logic              hit_ack,
  output logic              hit_miss,
  output logic              hit_destroyed,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  input  logic              cnt_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  bricks_left,
  output logic              win,
  output logic [15:0]       vid_stall_cnt
);

  localparam int BURST_W = $clog2(VID_BURST + 1);

  typedef enum logic {IDLE, HIT_WB} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   hit_addr_q, hit_addr_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [CNT_W-1:0]    bricks_q, bricks_d;
  logic                vid_rvalid_q, vid_rvalid_d;
  logic                cnt_inc, cnt_dec;
  logic                burst_full;

  assign burst_full = (burst_q == BURST_W'(VID_BURST));

  always_comb begin
    state_d       = state_q;
    hit_addr_d    = hit_addr_q;
    burst_d       = burst_q;
    vid_gnt       = 1'b0;
    hit_ack       = 1'b0;
    hit_miss      = 1'b0;
    hit_destroyed = 1'b0;
    load_gnt      = 1'b0;
    win           = 1'b0;
    mem_addr      = vid_addr;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    cnt_inc       = 1'b0;
    cnt_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        // Video wins unless it has used up its burst allowance against a
        // waiting hit.
        if (vid_req && !(burst_full && hit_req)) begin
          vid_gnt  = 1'b1;
          mem_addr = vid_addr;
          if (hit_req && !burst_full) begin
            burst_d = burst_q + BURST_W'(1);
          end
        end else if (hit_req) begin
          mem_addr   = hit_addr;
          hit_addr_d = hit_addr;
          burst_d    = '0;
          state_d    = HIT_WB;
        end else if (load_req) begin
          mem_addr  = load_addr;
          mem_we    = 1'b1;
          mem_wdata = load_data;
          load_gnt  = 1'b1;
          cnt_inc   = (load_data != '0);
        end
      end
      HIT_WB: begin
        // mem_rdata holds the value read in the preceding IDLE cycle.
        mem_addr = hit_addr_q;
        hit_ack  = 1'b1;
        state_d  = IDLE;
        if (mem_rdata == '0) begin
          hit_miss = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = mem_rdata - DATA_W'(1);
          if (mem_rdata == DATA_W'(1)) begin
            hit_destroyed = 1'b1;
            cnt_dec       = 1'b1;
            win           = (bricks_q == CNT_W'(1)) && !cnt_clr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The burst allowance only matters while a hit is waiting.
    if (!hit_req) begin
      burst_d = '0;
    end

    // Clear has top precedence; otherwise saturate at both ends.
    bricks_d = bricks_q;
    if (cnt_clr) begin
      bricks_d = '0;
    end else if (cnt_inc && (bricks_q != {CNT_W{1'b1}})) begin
      bricks_d = bricks_q + CNT_W'(1);
    end else if (cnt_dec && (bricks_q != '0)) begin
      bricks_d = bricks_q - CNT_W'(1);
    end

    vid_rvalid_d = vid_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hit_addr_q   <= '0;
      burst_q      <= '0;
      bricks_q     <= '0;
      vid_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_addr_q   <= hit_addr_d;
      burst_q      <= burst_d;
      bricks_q     <= bricks_d;
      vid_rvalid_q <= vid_rvalid_d;
    end
  end

  assign vid_rvalid  = vid_rvalid_q;
  // The RAM output register carries the data; gate it so it reads 0 when idle.
  assign vid_rdata   = vid_rvalid_q ? mem_rdata : '0;
  assign bricks_left = bricks_q;

`ifdef VID_STALL_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (cnt_clr) begin
      stall_d = '0;
    end else if (vid_req && !vid_gnt && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign vid_stall_cnt = stall_q;
`else
  assign vid_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_brick_map_arbiter.sv
module tb_brick_map_arbiter;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 2;
  localparam int CNT_W     = 7;
  localparam int VID_BURST = 8;
  localparam int CELLS     = 1 << ADDR_W;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              hit_req = 1'b0;
  logic [ADDR_W-1:0] hit_addr = '0;
  logic              hit_ack;
  logic              hit_miss;
  logic              hit_destroyed;
  logic              load_req = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_gnt;
  logic              cnt_clr = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [CNT_W-1:0]  bricks_left;
  logic              win;
  logic [15:0]       vid_stall_cnt;

  brick_map_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .VID_BURST(VID_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .hit_req(hit_req), .hit_addr(hit_addr), .hit_ack(hit_ack),
    .hit_miss(hit_miss), .hit_destroyed(hit_destroyed),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_gnt(load_gnt), .cnt_clr(cnt_clr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .bricks_left(bricks_left), .win(win),
    .vid_stall_cnt(vid_stall_cnt)
  );

  always #5 clk = ~clk;

  // External single-port RAM with a registered read.
  logic [DATA_W-1:0] ram [CELLS];
  initial for (int i = 0; i < CELLS; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: cell contents, brick count, stall count, win count.
  int model_mem [CELLS];
  int model_cnt   = 0;
  int model_stall = 0;
  int model_wins  = 0;
  int seen_wins   = 0;

  int total = 0;
  int bad   = 0;

  // Scoreboard queues.
  logic [DATA_W-1:0] vid_q [$];
  logic [11:0]       hit_q [$];   // {addr, miss, destroyed, win, we, wdata}
  logic [ADDR_W+DATA_W-1:0] load_q [$];

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=timeout/unexpected exp=event", nm);
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst) begin
      if (vid_rvalid) begin
        if (vid_q.size() == 0) fail("vid_unexpected");
        else begin
          logic [DATA_W-1:0] e;
          e = vid_q.pop_front();
          check("vid_rdata", 32'(vid_rdata), 32'(e));
          $display("vid  rdata=%0d", vid_rdata);
        end
      end
      if (hit_ack) begin
        if (hit_q.size() == 0) fail("hit_unexpected");
        else begin
          logic [11:0] e;
          e = hit_q.pop_front();
          check("hit_result",
                32'({mem_addr, hit_miss, hit_destroyed, win, mem_we, mem_we ? mem_wdata : 2'b00}),
                32'(e));
          $display("hit  addr=%0d miss=%0b destroyed=%0b win=%0b", mem_addr, hit_miss, hit_destroyed, win);
        end
      end
      if (load_gnt) begin
        if (load_q.size() == 0) fail("load_unexpected");
        else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = load_q.pop_front();
          check("load_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, e}));
          $display("load addr=%0d data=%0d", mem_addr, mem_wdata);
        end
      end
      if (win) begin
        seen_wins++;
        if (!hit_ack) fail("win_without_ack");
      end
    end
  end

  task automatic do_load(input int a, input int d);
    bit ok = 0;
    load_q.push_back({ADDR_W'(a), DATA_W'(d)});
    model_mem[a] = d;
    if (d != 0 && model_cnt < CNT_MAX) model_cnt++;
    load_req = 1'b1; load_addr = ADDR_W'(a); load_data = DATA_W'(d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (load_gnt) begin ok = 1; break; end
    end
    if (!ok) fail("load_timeout");
    @(posedge clk); #1;
    load_req = 1'b0;
    check("bricks_after_load", 32'(bricks_left), 32'(model_cnt));
  endtask

  task automatic do_vid(input int a);
    bit ok = 0;
    vid_q.push_back(DATA_W'(model_mem[a]));
    vid_req = 1'b1; vid_addr = ADDR_W'(a);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vid_gnt) begin ok = 1; break; end
    end
    if (!ok) fail("vid_timeout");
    @(posedge clk); #1;
    vid_req = 1'b0;
  endtask

  // Computes the expected hit outcome from the model and pushes it.
  task automatic expect_hit(input int a, input bit clr);
    int  old;
    bit  miss, dest, w;
    old  = model_mem[a];
    miss = (old == 0);
    dest = (old == 1);
    w    = dest && (model_cnt == 1) && !clr;
    if (!miss) model_mem[a] = old - 1;
    if (w) model_wins++;
    if (clr) begin model_cnt = 0; model_stall = 0; end
    else if (dest && model_cnt > 0) model_cnt--;
    hit_q.push_back({ADDR_W'(a), miss, dest, w, !miss, miss ? 2'b00 : DATA_W'(old - 1)});
  endtask

  task automatic do_hit(input int a, input bit clr);
    bit ok = 0;
    expect_hit(a, clr);
    hit_req = 1'b1; hit_addr = ADDR_W'(a);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hit_ack) begin ok = 1; break; end
      @(posedge clk); #1;
      if (clr) cnt_clr = 1'b1;
    end
    if (!ok) fail("hit_timeout");
    @(posedge clk); #1;
    hit_req = 1'b0; cnt_clr = 1'b0;
    check("bricks_after_hit", 32'(bricks_left), 32'(model_cnt));
  endtask

  task automatic do_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    model_cnt = 0; model_stall = 0;
    check("bricks_after_clr", 32'(bricks_left), 32'(model_cnt));
  endtask

  function automatic int stall_expect();
`ifdef VID_STALL_STATS_EN
    return model_stall;
`else
    return 0;
`endif
  endfunction

  initial begin
    int gnts;
    bit ok;
    int bad_cells;
    for (int i = 0; i < CELLS; i++) model_mem[i] = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_bricks", 32'(bricks_left), 0);
    check("rst_outputs", 32'({vid_gnt, vid_rvalid, vid_rdata, hit_ack, load_gnt, mem_we, win}), 0);
    check("rst_stall", 32'(vid_stall_cnt), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed level: load 2/1/0, then the hit sequence.
    do_clr();
    do_load(0, 2); do_load(1, 1); do_load(2, 0);
    do_vid(0); do_vid(1); do_vid(2);
    do_hit(0, 0);
    do_hit(1, 0);
    do_hit(0, 0);
    check("win_count_level", 32'(seen_wins), 32'(model_wins));
    do_hit(2, 0);

    // Video burst limit against a pending hit.
    do_load(5, 3); do_load(3, 2);
    for (int k = 0; k < VID_BURST; k++) vid_q.push_back(DATA_W'(model_mem[5]));
    expect_hit(3, 0);
    vid_req = 1'b1; vid_addr = 6'd5; hit_req = 1'b1; hit_addr = 6'd3;
    gnts = 0; ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vid_gnt) gnts++;
      if (hit_ack) begin ok = 1; break; end
    end
    if (!ok) fail("burst_hit_timeout");
    @(posedge clk); #1;
    vid_req = 1'b0; hit_req = 1'b0;
    model_stall += 2;
    check("burst_gnts", 32'(gnts), VID_BURST);
    check("burst_stall", 32'(vid_stall_cnt), 32'(stall_expect()));

    // Clear colliding with the final brick's destruction.
    do_clr();
    do_load(7, 1);
    do_hit(7, 1);

    // Reset during HIT_WB abandons the write.
    do_load(8, 2);
    hit_req = 1'b1; hit_addr = 6'd8;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_in_wb", 32'({mem_we, hit_ack}), 0);
    hit_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    model_cnt = 0; model_stall = 0;
    @(posedge clk); #1;
    check("bricks_after_rst", 32'(bricks_left), 0);
    do_vid(8);

    // Counter saturation.
    for (int i = 0; i < CNT_MAX + 3; i++) do_load(i % CELLS, 3);

    // Randomized traffic.
    do_clr();
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2)      do_vid($urandom_range(0, CELLS - 1));
      else if (r <= 5) do_hit($urandom_range(0, 15), 0);
      else if (r <= 8) do_load($urandom_range(0, 15), $urandom_range(0, 3));
      else             do_clr();
    end

    repeat (3) @(posedge clk); #1;
    check("queues_drained", 32'(vid_q.size() + hit_q.size() + load_q.size()), 0);
    check("win_count_total", 32'(seen_wins), 32'(model_wins));
    check("final_stall", 32'(vid_stall_cnt), 32'(stall_expect()));
    bad_cells = 0;
    for (int i = 0; i < CELLS; i++) if (int'(ram[i]) != model_mem[i]) bad_cells++;
    check("ram_image", 32'(bad_cells), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
